// File: rtl/vrf_pkg.sv
// Shared vector-register-file constants and types.
package vrf_pkg;

    localparam int unsigned VREG_W     = 512;
    localparam int unsigned VREG_IDX_W = 2;
    localparam int unsigned NUM_VREGS  = 4;

    typedef logic [VREG_IDX_W-1:0] vreg_idx_t;
    typedef logic [VREG_W-1:0]     vreg_data_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set bit of req_i at or after ptr_i, wrapping mod N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] idx_o,
    output logic          found_o
);

    always_comb begin
        int unsigned   j;
        logic [PW-1:0] jj;
        idx_o   = '0;
        found_o = 1'b0;
        j       = 0;
        jj      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = PW'(j);
            if (!found_o && req_i[jj]) begin
                found_o = 1'b1;
                idx_o   = jj;
            end
        end
    end

endmodule

// File: rtl/vrf_write_arbiter.sv
// Two-port round-robin write arbiter for the vector register file.
// Optional conflict counter enabled by defining VRF_ARB_CONFLICT_CNT_EN.
module vrf_write_arbiter
    import vrf_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = VREG_W,
    parameter int unsigned RW   = VREG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*RW-1:0]   req_reg,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 we1,
    output logic                 we2,
    output logic [RW-1:0]        in_reg1,
    output logic [RW-1:0]        in_reg2,
    output logic [DW-1:0]        in_data1,
    output logic [DW-1:0]        in_data2
`ifdef VRF_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]          conflict_cnt
`endif
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
        return (32'(v) + 1 >= NREQ) ? '0 : v + 1'b1;
    endfunction

    logic [RW-1:0]   reg_slot  [NREQ];
    logic [DW-1:0]   data_slot [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign reg_slot[g]  = req_reg[g*RW +: RW];
        assign data_slot[g] = req_data[g*DW +: DW];
    end

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   idx1, idx2, ptr2;
    logic            found1, found2;
    logic            grant1, grant2;
    logic [NREQ-1:0] same_reg, req2;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick1 (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (idx1),
        .found_o (found1)
    );

    // Requesters targeting port 1's register are held off so same-register
    // writes land on consecutive cycles in grant order.
    always_comb begin
        same_reg = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (reg_slot[i] == reg_slot[idx1]) && (PW'(i) != idx1)) begin
                same_reg[i] = 1'b1;
            end
        end
        req2       = req_valid & ~same_reg;
        req2[idx1] = 1'b0;
        ptr2       = inc_wrap(idx1);
    end

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick2 (
        .req_i   (req2),
        .ptr_i   (ptr2),
        .idx_o   (idx2),
        .found_o (found2)
    );

    assign grant1 = found1 & ~stall & ~rst;
    assign grant2 = found2 & grant1;

    always_comb begin
        req_ready = '0;
        if (grant1) begin
            req_ready[idx1] = 1'b1;
        end
        if (grant2) begin
            req_ready[idx2] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant1) begin
            ptr_d = grant2 ? inc_wrap(idx2) : inc_wrap(idx1);
        end
    end

    logic            we1_q, we2_q;
    logic [RW-1:0]   reg1_q, reg1_d, reg2_q, reg2_d;
    logic [DW-1:0]   data1_q, data1_d, data2_q, data2_d;

    always_comb begin
        reg1_d  = reg1_q;
        data1_d = data1_q;
        reg2_d  = reg2_q;
        data2_d = data2_q;
        if (grant1) begin
            reg1_d  = reg_slot[idx1];
            data1_d = data_slot[idx1];
        end
        if (grant2) begin
            reg2_d  = reg_slot[idx2];
            data2_d = data_slot[idx2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            we1_q   <= 1'b0;
            we2_q   <= 1'b0;
            reg1_q  <= '0;
            reg2_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            we1_q   <= grant1;
            we2_q   <= grant2;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    assign we1      = we1_q;
    assign we2      = we2_q;
    assign in_reg1  = reg1_q;
    assign in_reg2  = reg2_q;
    assign in_data1 = data1_q;
    assign in_data2 = data2_q;

`ifdef VRF_ARB_CONFLICT_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (grant1 && (|same_reg) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: doc/vrf_write_arbiter.md
VRF_WRITE_ARBITER -- requirements
Module: vrf_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DW, default 512, vector register data width.
REQ-003 Parameter RW, default 2, register index width (4 vector registers).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  when 1, no grants are issued.
REQ-008 req_valid  in  NREQ  per-requester write request.
REQ-009 req_ready  out  NREQ  per-requester grant (handshake complete when valid&ready).
REQ-010 req_reg  in  NREQ*RW  destination register per requester; slot i at [i*RW +: RW].
REQ-011 req_data  in  NREQ*DW  write data per requester; slot i at [i*DW +: DW].
REQ-012 we1, we2  out  1 each  register-file write enables, port 1 and port 2.
REQ-013 in_reg1, in_reg2  out  RW each  register-file write indices.
REQ-014 in_data1, in_data2  out  DW each  register-file write data.

Function
REQ-015 Round-robin pointer ptr (0..NREQ-1) SHALL set search order ptr, ptr+1, ... wrapping mod NREQ.
REQ-016 First valid requester in search order SHALL be granted port 1.
REQ-017 Next valid requester after it, whose req_reg differs from port 1's, SHALL be granted port 2; at most 2 grants per cycle.
REQ-018 A valid requester whose req_reg equals port 1's SHALL NOT be granted that cycle; it remains pending and the search continues past it.
REQ-019 req_ready SHALL be combinational from req_valid, req_reg, ptr and stall; req_ready[i]=1 only if requester i is granted.
REQ-020 Requesters SHALL hold valid/reg/data stable until ready; the block SHALL NOT buffer ungranted requests.
REQ-021 Port outputs SHALL be registered: grant at edge N -> weX=1 with granted reg/data during cycle N+1; weX=0 otherwise.
REQ-022 A single grant SHALL always use port 1; port 2 with we2=1 requires we1=1 in the same cycle.
REQ-023 After any grant, ptr SHALL become (index of last granted requester + 1) mod NREQ; with no grant, ptr unchanged.
REQ-024 stall=1 SHALL force req_ready=0, next we1=we2=0, ptr unchanged.
REQ-025 in_reg/in_data SHALL hold their last value when the matching weX=0.
REQ-026 Two accepted writes to one register SHALL be presented in grant order on consecutive cycles, never in the same cycle.

Reset
REQ-027 While rst=1: ptr=0, we1=we2=0, in_reg1=in_reg2=0, in_data1=in_data2=0, req_ready=0.
REQ-028 Reset mid-operation SHALL drop a granted-but-not-yet-presented write; the first grant after release is evaluated from ptr=0.

Configuration
REQ-029 With macro VRF_ARB_CONFLICT_CNT_EN defined: output conflict_cnt (16 bits), reset 0, incremented by 1 (saturating at 16'hFFFF) in each cycle with stall=0 where any valid requester is denied under REQ-018.
REQ-030 Without VRF_ARB_CONFLICT_CNT_EN: no conflict_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-031 Shared package vrf_pkg SHALL hold VREG_W=512, VREG_IDX_W=2, NUM_VREGS=4 and typedefs vreg_idx_t, vreg_data_t.
REQ-032 Round-robin search SHALL be a sub-module rr_pick (inputs: request mask, ptr; output: first index plus found flag), instantiated twice (port 1, then port 2 with masked requests).

Verification
REQ-033 Single request: req_valid=0001, reg=2, data=A5.. -> ready[0]=1 same cycle; next cycle we1=1, in_reg1=2, in_data1=A5..; we2=0; ptr=1.
REQ-034 Dual grant: all 4 valid, regs 0,1,2,3, ptr=0 -> ready=0011; next cycle port1=req0/reg0, port2=req1/reg1; ptr=2; following cycle req2, req3 granted.
REQ-035 Conflict: req0 and req1 valid both reg 3, ptr=0 -> cycle 1 only req0 granted (conflict_cnt=1 if enabled); cycle 2 req1 granted; writes reg3 on consecutive cycles in order req0, req1.
REQ-036 Wrap/fairness: NREQ=4 all valid continuously, distinct regs -> each requester granted exactly once per 2 cycles; ptr sequence 0,2,0,2.
REQ-037 Stall: all valid, stall=1 for 3 cycles -> req_ready=0, we1=we2=0, ptr unchanged; first cycle after stall=0 grants per REQ-016/017.
REQ-038 Reset mid-op: grant req2 at edge N, assert rst before N+1 -> we1=0, ptr=0; no write presented.
